game_turn_ctrl: RTL and testbench

- Central sequencer for one game round: holds the current player, runs each turn select -> reveal -> advance-or-pass, and tracks every player's track position.
- Sits between the card-input/debounce logic and the display/board drivers.
- Owns the turn rotation for 2, 3 or 4 players and declares the winner.

---
 rtl/game_turn_ctrl.sv | 119 +++++++++++
 tb/tb_game_turn_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_turn_ctrl.sv
// Turn sequencer for one game round: rotates 2-4 players through select, reveal and
// advance-or-pass, tracks every player's track position and declares the winner.
module game_turn_ctrl #(
   parameter int TRACK_LEN    = 24,
   parameter int POS_W        = 5,
   parameter int REVEAL_TICKS = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [1:0]           num_players,
   input  logic                 tick,
   input  logic                 card_valid,
   input  logic                 card_match,
   output logic [2:0]           state,
   output logic [1:0]           turn,
   output logic                 reveal_active,
   output logic [4*POS_W-1:0]   positions,
   output logic                 winner_valid,
   output logic [1:0]           winner
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SELECT  = 3'd1,
      REVEAL  = 3'd2,
      ADVANCE = 3'd3,
      NEXT    = 3'd4,
      DONE    = 3'd5
   } state_t;

   localparam int                CNT_W    = $clog2(REVEAL_TICKS + 1);
   localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(REVEAL_TICKS);
   localparam logic [POS_W-1:0]  WIN_POS  = POS_W'(TRACK_LEN - 1);

   state_t            state_q;
   logic [1:0]        turn_q;
   logic [1:0]        players_q;
   logic [1:0]        winner_q;
   logic              winner_valid_q;
   logic              match_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [POS_W-1:0]  pos_q [4];

   logic [POS_W-1:0]  pos_inc_d;
   logic [1:0]        last_player_d;

   // Latched count 00/01/10 maps to highest player index 1/2/3.
   always_comb begin
      pos_inc_d     = pos_q[turn_q] + POS_W'(1);
      last_player_d = players_q + 2'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= IDLE;
         turn_q         <= 2'd0;
         players_q      <= 2'd0;
         winner_q       <= 2'd0;
         winner_valid_q <= 1'b0;
         match_q        <= 1'b0;
         cnt_q          <= '0;
         for (int i = 0; i < 4; i++) pos_q[i] <= '0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (start && num_players != 2'b11) begin
                  players_q      <= num_players;
                  turn_q         <= 2'd0;
                  winner_q       <= 2'd0;
                  winner_valid_q <= 1'b0;
                  for (int i = 0; i < 4; i++) pos_q[i] <= '0;
                  state_q        <= SELECT;
               end
            end
            SELECT: begin
               if (card_valid) begin
                  match_q <= card_match;
                  cnt_q   <= CNT_LOAD;
                  state_q <= REVEAL;
               end
            end
            REVEAL: begin
               if (tick) begin
                  cnt_q <= cnt_q - CNT_W'(1);
                  if (cnt_q == CNT_W'(1)) state_q <= match_q ? ADVANCE : NEXT;
               end
            end
            ADVANCE: begin
               // Saturate at the winning tile so a position can never run past the track.
               if (pos_q[turn_q] < WIN_POS) pos_q[turn_q] <= pos_inc_d;
               if (pos_inc_d == WIN_POS) begin
                  winner_q       <= turn_q;
                  winner_valid_q <= 1'b1;
                  state_q        <= DONE;
               end else begin
                  state_q <= SELECT;
               end
            end
            NEXT: begin
               turn_q  <= (turn_q == last_player_d) ? 2'd0 : turn_q + 2'd1;
               state_q <= SELECT;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign state         = state_q;
   assign turn          = turn_q;
   assign reveal_active = (state_q == REVEAL);
   assign winner_valid  = winner_valid_q;
   assign winner        = winner_q;

   for (genvar gi = 0; gi < 4; gi++) begin : g_pos
      assign positions[gi*POS_W +: POS_W] = pos_q[gi];
   end

endmodule

// File: tb/tb_game_turn_ctrl.sv
// Randomized bench for game_turn_ctrl: a turn-level game model predicts turn, positions,
// state and winner after every card; each scenario task checks its own results.
module tb_game_turn_ctrl;
   localparam int TL = 4;
   localparam int PW = 5;
   localparam int RT = 4;

   logic          clk = 1'b0;
   logic          rst, start, tick, card_valid, card_match;
   logic [1:0]    num_players;
   logic [2:0]    state;
   logic [1:0]    turn, winner;
   logic          reveal_active, winner_valid;
   logic [4*PW-1:0] positions;

   game_turn_ctrl #(.TRACK_LEN(TL), .POS_W(PW), .REVEAL_TICKS(RT)) dut (
      .clk(clk), .rst(rst), .start(start), .num_players(num_players), .tick(tick),
      .card_valid(card_valid), .card_match(card_match), .state(state), .turn(turn),
      .reveal_active(reveal_active), .positions(positions), .winner_valid(winner_valid),
      .winner(winner));

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Game model: player count, whose turn, tile per player, expected state code.
   int m_n, m_turn, m_done, m_win, m_st;
   int m_pos [4];

   wire [28:0] obs = {state, turn, positions, winner_valid, winner, reveal_active};

   function automatic logic [28:0] exp_vec();
      logic [4*PW-1:0] p;
      p = '0;
      for (int i = 0; i < 4; i++) p[i*PW +: PW] = PW'(m_pos[i]);
      return {3'(m_st), 2'(m_turn), p, 1'(m_done), 2'(m_win), 1'b0};
   endfunction

   task automatic model_reset();
      m_n = 2; m_turn = 0; m_done = 0; m_win = 0; m_st = 0;
      for (int i = 0; i < 4; i++) m_pos[i] = 0;
   endtask

   task automatic model_start(input int n);
      model_reset();
      m_n = n + 2; m_st = 1;
   endtask

   task automatic model_card(input bit m);
      if (m) begin
         m_pos[m_turn]++;
         if (m_pos[m_turn] == TL - 1) begin
            m_done = 1; m_win = m_turn; m_st = 5;
         end
      end else begin
         m_turn = (m_turn + 1) % m_n;
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      cyc();
      model_reset();
   endtask

   task automatic do_start(input logic [1:0] n);
      start = 1'b1; num_players = n;
      cyc();
      start = 1'b0;
      num_players = 2'($urandom);
   endtask

   // Flip one card, then feed random ticks and stray cards until the reveal ends.
   task automatic do_card(input bit m, output int ticks, output logic [2:0] st_mid);
      card_valid = 1'b1; card_match = m; tick = 1'($urandom);
      cyc();
      card_valid = 1'b0; tick = 1'b0;
      ticks = 0;
      for (int k = 0; k < 200 && reveal_active; k++) begin
         tick = 1'($urandom);
         card_valid = ($urandom_range(0, 3) == 0);
         card_match = 1'($urandom);
         if (tick) ticks++;
         cyc();
      end
      tick = 1'b0; card_valid = 1'b0;
      st_mid = state;
      cyc();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1;
      model_reset();
      n_cmp++;
      if (obs !== exp_vec()) begin n_bad++; $display("FAIL reset_async: got %h want %h", obs, exp_vec()); end
      repeat (2) cyc();
      rst = 1'b0;
      cyc();
      n_cmp++;
      if (obs !== exp_vec()) begin n_bad++; $display("FAIL reset_idle: got %h want %h", obs, exp_vec()); end
   endtask

   task automatic test_two_players();
      int t; logic [2:0] sm;
      do_reset();
      do_start(2'b00); model_start(0);
      n_cmp++;
      if (obs !== exp_vec()) begin n_bad++; $display("FAIL two_start: got %h want %h", obs, exp_vec()); end
      for (int c = 0; c < 2; c++) begin
         model_card(1'b0);
         do_card(1'b0, t, sm);
         n_cmp++;
         if ({t, sm} !== {RT, 3'd4}) begin n_bad++; $display("FAIL two_reveal: got ticks %0d mid %0d want %0d 4", t, sm, RT); end
         n_cmp++;
         if (obs !== exp_vec()) begin n_bad++; $display("FAIL two_turn: got %h want %h", obs, exp_vec()); end
      end
   endtask

   task automatic test_four_players();
      int t; logic [2:0] sm;
      do_reset();
      do_start(2'b10); model_start(2);
      for (int c = 0; c < 4; c++) begin
         model_card(1'b0);
         do_card(1'b0, t, sm);
         n_cmp++;
         if ({t, sm} !== {RT, 3'd4}) begin n_bad++; $display("FAIL four_reveal: got ticks %0d mid %0d want %0d 4", t, sm, RT); end
         n_cmp++;
         if (obs !== exp_vec()) begin n_bad++; $display("FAIL four_turn: got %h want %h", obs, exp_vec()); end
      end
   endtask

   task automatic test_three_players();
      int t; logic [2:0] sm;
      do_reset();
      do_start(2'b01); model_start(1);
      model_card(1'b1);
      do_card(1'b1, t, sm);
      n_cmp++;
      if ({t, sm} !== {RT, 3'd3}) begin n_bad++; $display("FAIL three_match: got ticks %0d mid %0d want %0d 3", t, sm, RT); end
      n_cmp++;
      if (obs !== exp_vec()) begin n_bad++; $display("FAIL three_keep: got %h want %h", obs, exp_vec()); end
      do_start(2'b10);
      n_cmp++;
      if (obs !== exp_vec()) begin n_bad++; $display("FAIL three_start_ignored: got %h want %h", obs, exp_vec()); end
      model_card(1'b0);
      do_card(1'b0, t, sm);
      n_cmp++;
      if (obs !== exp_vec()) begin n_bad++; $display("FAIL three_pass: got %h want %h", obs, exp_vec()); end
   endtask

   task automatic test_win();
      int t; logic [2:0] sm;
      do_reset();
      do_start(2'b00); model_start(0);
      for (int c = 0; c < 3; c++) begin
         model_card(1'b1);
         do_card(1'b1, t, sm);
         n_cmp++;
         if (obs !== exp_vec()) begin n_bad++; $display("FAIL win_step%0d: got %h want %h", c, obs, exp_vec()); end
      end
      card_valid = 1'b1; card_match = 1'b1; tick = 1'b1;
      repeat (5) cyc();
      card_valid = 1'b0; tick = 1'b0;
      n_cmp++;
      if (obs !== exp_vec()) begin n_bad++; $display("FAIL win_hold: got %h want %h", obs, exp_vec()); end
      do_start(2'b11);
      n_cmp++;
      if (obs !== exp_vec()) begin n_bad++; $display("FAIL win_bad_start: got %h want %h", obs, exp_vec()); end
      do_start(2'b00); model_start(0);
      n_cmp++;
      if (obs !== exp_vec()) begin n_bad++; $display("FAIL win_restart: got %h want %h", obs, exp_vec()); end
   endtask

   task automatic test_invalid_start();
      int t; logic [2:0] sm;
      do_reset();
      do_start(2'b11);
      n_cmp++;
      if (obs !== exp_vec()) begin n_bad++; $display("FAIL inv_ignored: got %h want %h", obs, exp_vec()); end
      start = 1'b1; num_players = 2'b01; card_valid = 1'b1; card_match = 1'b1;
      cyc();
      start = 1'b0; card_valid = 1'b0; num_players = 2'b11;
      cyc();
      model_start(1);
      n_cmp++;
      if (obs !== exp_vec()) begin n_bad++; $display("FAIL inv_start_wins: got %h want %h", obs, exp_vec()); end
      for (int c = 0; c < 3; c++) begin
         model_card(1'b0);
         do_card(1'b0, t, sm);
         n_cmp++;
         if (obs !== exp_vec()) begin n_bad++; $display("FAIL inv_wrap%0d: got %h want %h", c, obs, exp_vec()); end
      end
   endtask

   task automatic test_reset_mid_reveal();
      int t; logic [2:0] sm;
      do_reset();
      do_start(2'b00); model_start(0);
      model_card(1'b0); do_card(1'b0, t, sm);
      model_card(1'b1); do_card(1'b1, t, sm);
      model_card(1'b1); do_card(1'b1, t, sm);
      n_cmp++;
      if (obs !== exp_vec()) begin n_bad++; $display("FAIL rstmid_setup: got %h want %h", obs, exp_vec()); end
      card_valid = 1'b1; card_match = 1'b1;
      cyc();
      card_valid = 1'b0;
      cyc();
      #2 rst = 1'b1;
      #1;
      model_reset();
      n_cmp++;
      if (obs !== exp_vec()) begin n_bad++; $display("FAIL rstmid_same_cycle: got %h want %h", obs, exp_vec()); end
      cyc();
      rst = 1'b0;
      cyc();
      n_cmp++;
      if (obs !== exp_vec()) begin n_bad++; $display("FAIL rstmid_after: got %h want %h", obs, exp_vec()); end
   endtask

   task automatic test_random();
      int t; logic [2:0] sm; logic [1:0] n; bit m;
      do_reset();
      for (int g = 0; g < 8; g++) begin
         if (!m_done && m_st != 0) do_reset();
         n = 2'($urandom_range(0, 3));
         do_start(n);
         if (n != 2'b11) model_start(int'(n));
         n_cmp++;
         if (obs !== exp_vec()) begin n_bad++; $display("FAIL rnd_start g%0d n%0d: got %h want %h", g, n, obs, exp_vec()); end
         if (n == 2'b11) continue;
         for (int c = 0; c < 60 && !m_done; c++) begin
            m = ($urandom_range(0, 99) < 45);
            model_card(m);
            do_card(m, t, sm);
            n_cmp++;
            if ({t, sm} !== {RT, (m ? 3'd3 : 3'd4)}) begin n_bad++; $display("FAIL rnd_reveal g%0d c%0d: got ticks %0d mid %0d want %0d %0d", g, c, t, sm, RT, m ? 3 : 4); end
            n_cmp++;
            if (obs !== exp_vec()) begin n_bad++; $display("FAIL rnd_card g%0d c%0d: got %h want %h", g, c, obs, exp_vec()); end
         end
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; tick = 1'b0; card_valid = 1'b0; card_match = 1'b0;
      num_players = 2'b00;
      test_reset();
      test_two_players();
      test_four_players();
      test_three_players();
      test_win();
      test_invalid_start();
      test_reset_mid_reveal();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
